// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back scheduler slice.
package wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned RIDX_W = $clog2(NREG);

  typedef logic [RIDX_W-1:0] reg_idx_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write bitmap with set-over-clear priority and RAW hazard detection.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int unsigned NREG = wb_pkg::NREG,
  parameter int unsigned IW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set_en,
  input  logic [IW-1:0] set_rd,
  input  logic          clr_en,
  input  logic [IW-1:0] clr_rd,
  input  logic [IW-1:0] rs1,
  input  logic [IW-1:0] rs2,
  output logic          hazard
);

  logic [NREG-1:0] busy_q, busy_d;

  // Set is applied after clear so a newly issued write to the same rd stays pending.
  always_comb begin
    busy_d = busy_q;
    if (clr_en && clr_rd != '0) busy_d[clr_rd] = 1'b0;
    if (set_en && set_rd != '0) busy_d[set_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Gated by reset so the issue stage sees an empty scoreboard while reset is held.
  assign hazard = !reset && ((busy_q[rs1] && rs1 != '0) ||
                             (busy_q[rs2] && rs2 != '0));

endmodule

// File: rtl/wb_sched.sv
// Two-source round-robin write-back arbiter with registered regfile write port.
module wb_sched
  import wb_pkg::*;
#(
  parameter int unsigned XLEN = wb_pkg::XLEN,
  parameter int unsigned NREG = wb_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  input  logic [$clog2(NREG)-1:0] a_rd,
  input  logic [XLEN-1:0]         a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [$clog2(NREG)-1:0] b_rd,
  input  logic [XLEN-1:0]         b_data,
  output logic                    b_ready,
  input  logic                    iss_valid,
  input  logic [$clog2(NREG)-1:0] iss_rd,
  input  logic [$clog2(NREG)-1:0] rs1,
  input  logic [$clog2(NREG)-1:0] rs2,
  output logic                    hazard,
  output logic                    wr_req,
  output logic [$clog2(NREG)-1:0] wr_rd,
  output logic [XLEN-1:0]         wr_data
);

  localparam int unsigned IW = $clog2(NREG);

  port_e           last_q, last_d;
  logic            wr_req_q, wr_req_d;
  logic [IW-1:0]   wr_rd_q, wr_rd_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  logic            xfer_a, xfer_b, acc;
  logic [IW-1:0]   acc_rd;
  logic [XLEN-1:0] acc_data;

  assign a_ready = !b_valid || (last_q == PORT_B);
  assign b_ready = !a_valid || (last_q == PORT_A);

  assign xfer_a   = a_valid && a_ready;
  assign xfer_b   = b_valid && b_ready;
  assign acc      = xfer_a || xfer_b;
  assign acc_rd   = xfer_a ? a_rd   : b_rd;
  assign acc_data = xfer_a ? a_data : b_data;

  // x0 results are consumed but never reach the regfile; rd/data hold like an idle cycle.
  always_comb begin
    last_d    = last_q;
    wr_req_d  = acc && (acc_rd != '0);
    wr_rd_d   = wr_rd_q;
    wr_data_d = wr_data_q;
    if (a_valid && b_valid) last_d = xfer_a ? PORT_A : PORT_B;
    if (wr_req_d) begin
      wr_rd_d   = acc_rd;
      wr_data_d = acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q    <= PORT_B;
      wr_req_q  <= 1'b0;
      wr_rd_q   <= '0;
      wr_data_q <= '0;
    end else begin
      last_q    <= last_d;
      wr_req_q  <= wr_req_d;
      wr_rd_q   <= wr_rd_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_req  = wr_req_q;
  assign wr_rd   = wr_rd_q;
  assign wr_data = wr_data_q;

  wb_scoreboard #(.NREG(NREG), .IW(IW)) u_sb (
    .clk    (clk),
    .reset  (reset),
    .set_en (iss_valid),
    .set_rd (iss_rd),
    .clr_en (acc),
    .clr_rd (acc_rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .hazard (hazard)
  );

endmodule
